// File: rtl/octet_fetch_unit.sv
// octet_fetch_unit: fetches 14 operand words (A0-A1, B0-B3, C0-C7) from memory into operand buffers
module octet_fetch_unit #(
  parameter int DATA_WIDTH      = 64,
  parameter int MEM_ADDR_WIDTH  = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_req,
  input  logic [MEM_ADDR_WIDTH-1:0] a_base,
  input  logic [MEM_ADDR_WIDTH-1:0] b_base,
  input  logic [MEM_ADDR_WIDTH-1:0] c_base,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
  output logic                      buf_wr_en,
  output logic [1:0]                buf_sel,
  output logic [2:0]                buf_wr_addr,
  output logic [DATA_WIDTH-1:0]     buf_wr_data,
  output logic                      busy,
  output logic                      fetch_done,
  output logic                      rsp_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [MEM_ADDR_WIDTH-1:0] a_q, b_q, c_q, iss_base;
  logic [3:0] iss_idx, rsp_idx;
  logic [2:0] outst, iss_ent, rsp_ent;
  logic [1:0] rsp_seg;
  logic active, issue, rsp_acc, dec;
  always_comb begin
    active        = state == ISSUE || state == DRAIN;
    mem_req_valid = state == ISSUE && outst < 3'(MAX_OUTSTANDING);
    issue         = mem_req_valid && mem_req_ready;
    rsp_acc       = active && mem_rsp_valid;
    dec           = rsp_acc && outst != 3'd0;
    iss_base      = iss_idx < 4'd2 ? a_q : iss_idx < 4'd6 ? b_q : c_q;
    iss_ent       = iss_idx < 4'd2 ? iss_idx[2:0] : iss_idx < 4'd6 ? 3'(iss_idx - 4'd2) : 3'(iss_idx - 4'd6);
    mem_req_addr  = mem_req_valid ? iss_base + MEM_ADDR_WIDTH'(iss_ent) : '0;
    rsp_seg       = rsp_idx < 4'd2 ? 2'd0 : rsp_idx < 4'd6 ? 2'd1 : 2'd2;
    rsp_ent       = rsp_idx < 4'd2 ? rsp_idx[2:0] : rsp_idx < 4'd6 ? 3'(rsp_idx - 4'd2) : 3'(rsp_idx - 4'd6);
    buf_wr_en     = rsp_acc;
    buf_sel       = rsp_acc ? rsp_seg : 2'd0;
    buf_wr_addr   = rsp_acc ? rsp_ent : 3'd0;
    buf_wr_data   = rsp_acc ? mem_rsp_data : '0;
    busy          = active;
    fetch_done    = state == DONE;
    state_nx      = state == IDLE ? (fetch_req ? ISSUE : IDLE) :
                    state == DONE ? IDLE :
                    rsp_acc && rsp_idx == 4'd13 ? DONE :
                    issue && iss_idx == 4'd13 ? DRAIN : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      iss_idx <= '0;
      rsp_idx <= '0;
      outst   <= '0;
      rsp_err <= 1'b0;
    end else begin
      state   <= state_nx;
      rsp_err <= rsp_err | (mem_rsp_valid && (!active || outst == 3'd0));
      if (state == IDLE && fetch_req) begin
        a_q     <= a_base;
        b_q     <= b_base;
        c_q     <= c_base;
        iss_idx <= '0;
        rsp_idx <= '0;
        outst   <= '0;
      end else begin
        if (issue) iss_idx <= iss_idx + 4'd1;
        if (rsp_acc) rsp_idx <= rsp_idx + 4'd1;
        outst <= outst + 3'(issue) - 3'(dec);
      end
    end
  end
endmodule

// File: tb/tb_octet_fetch_unit.sv
// tb_octet_fetch_unit: directed and randomized checks of octet_fetch_unit against an in-order memory model
module tb_octet_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, fetch_req = 1'b0;
  logic [15:0] a_base = '0, b_base = '0, c_base = '0;
  logic mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [15:0] mem_req_addr;
  logic [63:0] mem_rsp_data;
  logic buf_wr_en, busy, fetch_done, rsp_err;
  logic [1:0] buf_sel;
  logic [2:0] buf_wr_addr;
  logic [63:0] buf_wr_data;
  logic rand_mode = 1'b0, rdy_man = 1'b1, rdy_rand = 1'b1, inj = 1'b0, mem_flush = 1'b0, mv = 1'b0;
  logic [63:0] md = '0;
  logic [47:0] salt;
  int lat = 1, rsp_limit = 32'h7fffffff, served = 0, cyc = 0;
  int checks = 0, failures = 0, zero_bad = 0, stab_bad = 0, done_cnt = 0, out_tb = 0, max_out = 0;
  logic pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [15:0] pa = '0;
  logic [15:0] pend[$];
  int due[$];
  logic [15:0] reqs[$];
  logic [1:0] wsel[$];
  logic [2:0] waddr[$];
  logic [63:0] wdata[$];

  assign mem_req_ready = rand_mode ? rdy_rand : rdy_man;
  assign mem_rsp_valid = mv | inj;
  assign mem_rsp_data  = md;

  octet_fetch_unit dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .buf_wr_en(buf_wr_en), .buf_sel(buf_sel), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .busy(busy), .fetch_done(fetch_done), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Memory returns {salt, address} in order, lat cycles after acceptance, up to rsp_limit total responses
  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) reqs.push_back(mem_req_addr);
    if (buf_wr_en) begin
      wsel.push_back(buf_sel);
      waddr.push_back(buf_wr_addr);
      wdata.push_back(buf_wr_data);
    end
    if (!buf_wr_en && (buf_sel != 2'd0 || buf_wr_addr != 3'd0 || buf_wr_data != 64'd0)) zero_bad++;
    if (pv && !pr && !prst && (!mem_req_valid || mem_req_addr != pa)) stab_bad++;
    pv = mem_req_valid;
    pr = mem_req_ready;
    pa = mem_req_addr;
    prst = rst;
    if (fetch_done) done_cnt++;
    out_tb = rst ? 0 : out_tb + int'(mem_req_valid && mem_req_ready) - int'(buf_wr_en);
    if (out_tb > max_out) max_out = out_tb;
    rdy_rand <= $urandom_range(0, 3) != 0;
    if (mem_flush) begin
      pend.delete();
      due.delete();
      mv <= 1'b0;
      md <= '0;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        pend.push_back(mem_req_addr);
        due.push_back(cyc + lat);
      end
      cyc++;
      if (pend.size() > 0 && due[0] <= cyc && served < rsp_limit) begin
        mv <= 1'b1;
        md <= {salt, pend[0]};
        void'(pend.pop_front());
        void'(due.pop_front());
        served++;
      end else begin
        mv <= 1'b0;
        md <= '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_addr(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    if (i < 2) return a + 16'(i);
    if (i < 6) return b + 16'(i - 2);
    return c + 16'(i - 6);
  endfunction

  task automatic check_seq(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input int r0, input int w0);
    chk("req_count", 64'(reqs.size() - r0), 64'd14);
    chk("wr_count", 64'(wrs_size() - w0), 64'd14);
    for (int i = 0; i < 14; i++) begin
      if (r0 + i < reqs.size()) chk($sformatf("req_addr[%0d]", i), 64'(reqs[r0 + i]), 64'(exp_addr(i, a, b, c)));
      if (w0 + i < wsel.size()) begin
        chk($sformatf("wr_sel[%0d]", i), 64'(wsel[w0 + i]), i < 2 ? 64'd0 : i < 6 ? 64'd1 : 64'd2);
        chk($sformatf("wr_entry[%0d]", i), 64'(waddr[w0 + i]), i < 2 ? 64'(i) : i < 6 ? 64'(i - 2) : 64'(i - 6));
        chk($sformatf("wr_data[%0d]", i), wdata[w0 + i], {salt, exp_addr(i, a, b, c)});
      end
    end
  endtask

  function automatic int wrs_size();
    return wsel.size();
  endfunction

  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    a_base = a;
    b_base = b;
    c_base = c;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  // Returns the cycle count from the fetch_req cycle to the fetch_done cycle (-1 on timeout)
  task automatic wait_done(input int already, output int n);
    n = already;
    while (!fetch_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(fetch_done), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd0);
    if (!fetch_done) n = -1;
  endtask

  task automatic run_xfer(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, output int n);
    start(a, b, c);
    wait_done(1, n);
  endtask

  initial begin
    int n, r0, w0, d0, k;
    salt = {$urandom(), $urandom()};
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_addr", 64'(mem_req_addr), 64'd0);
    chk("rst_wr_en", 64'(buf_wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(fetch_done), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    r0 = reqs.size(); w0 = wsel.size();
    run_xfer(16'h100, 16'h200, 16'h300, n);
    chk("latency_min", 64'(n), 64'd16);
    check_seq(16'h100, 16'h200, 16'h300, r0, w0);
    @(negedge clk);

    r0 = reqs.size(); w0 = wsel.size();
    start(16'h100, 16'h200, 16'h300);
    k = 0;
    while (reqs.size() - r0 < 5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    rdy_man = 1'b0;
    repeat (3) begin
      chk("stall_valid", 64'(mem_req_valid), 64'd1);
      chk("stall_addr", 64'(mem_req_addr), 64'h203);
      @(negedge clk);
    end
    rdy_man = 1'b1;
    wait_done(0, n);
    check_seq(16'h100, 16'h200, 16'h300, r0, w0);
    @(negedge clk);

    r0 = reqs.size();
    rsp_limit = served;
    start(16'h0040, 16'h0080, 16'h00c0);
    repeat (20) @(negedge clk);
    chk("cap_reqs", 64'(reqs.size() - r0), 64'd4);
    chk("cap_valid", 64'(mem_req_valid), 64'd0);
    chk("cap_busy", 64'(busy), 64'd1);
    rst = 1'b1; mem_flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_flush = 1'b0; rsp_limit = 32'h7fffffff;
    chk("cap_rst_busy", 64'(busy), 64'd0);
    chk("cap_rst_err", 64'(rsp_err), 64'd0);

    r0 = reqs.size(); w0 = wsel.size();
    run_xfer(16'h1234, 16'h8000, 16'hfffc, n);
    check_seq(16'h1234, 16'h8000, 16'hfffc, r0, w0);
    chk("wrap_c4", 64'(reqs[r0 + 10]), 64'h0000);
    chk("wrap_c7", 64'(reqs[r0 + 13]), 64'h0003);
    @(negedge clk);

    r0 = reqs.size(); w0 = wsel.size();
    start(16'h1000, 16'h2000, 16'h3000);
    repeat (2) @(negedge clk);
    start(16'h4444, 16'h5555, 16'h6666);
    wait_done(4, n);
    repeat (5) @(negedge clk);
    check_seq(16'h1000, 16'h2000, 16'h3000, r0, w0);
    inj = 1'b1;
    chk("idle_rsp_wr_en", 64'(buf_wr_en), 64'd0);
    @(negedge clk);
    inj = 1'b0;
    chk("idle_rsp_err", 64'(rsp_err), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_cleared", 64'(rsp_err), 64'd0);

    r0 = reqs.size(); w0 = wsel.size(); d0 = done_cnt;
    lat = 3;
    rsp_limit = served + 10;
    start(16'h0a00, 16'h0b00, 16'h0c00);
    k = 0;
    while (!(reqs.size() - r0 == 14 && wsel.size() - w0 == 10) && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_writes", 64'(wsel.size() - w0), 64'd10);
    rst = 1'b1; mem_flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_flush = 1'b0; rsp_limit = 32'h7fffffff; lat = 1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(mem_req_valid), 64'd0);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    r0 = reqs.size(); w0 = wsel.size();
    run_xfer(16'h0d00, 16'h0e00, 16'h0f00, n);
    chk("restart_latency", 64'(n), 64'd16);
    check_seq(16'h0d00, 16'h0e00, 16'h0f00, r0, w0);
    @(negedge clk);

    rand_mode = 1'b1;
    d0 = done_cnt;
    for (int t = 0; t < 8; t++) begin
      logic [15:0] a, b, c;
      a = 16'($urandom()); b = 16'($urandom()); c = 16'($urandom());
      lat = $urandom_range(1, 6);
      r0 = reqs.size(); w0 = wsel.size();
      run_xfer(a, b, c, n);
      chk("rand_latency_ge16", 64'(n >= 16), 64'd1);
      check_seq(a, b, c, r0, w0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    chk("rand_done_count", 64'(done_cnt - d0), 64'd8);
    chk("rand_rsp_err", 64'(rsp_err), 64'd0);
    chk("max_outstanding", 64'(max_out <= 4), 64'd1);
    chk("req_stability", 64'(stab_bad), 64'd0);
    chk("idle_outputs_zero", 64'(zero_bad), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
